pipe_ctrl: RTL and testbench

Pipeline stall/flush controller for the 5-stage tinyriscv core. It watches ID source registers, the EX-stage instruction and the data-memory handshake, and drives the `stop`/flush controls of the PC register and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It resolves load-use hazards, taken-branch redirects, data-memory wait states and, optionally, a fixed-latency multi-cycle divider, with a defined priority between them.

---
 rtl/pipe_ctrl_pkg.sv | 35 +++
 rtl/pipe_ctrl_div_timer.sv | 54 +++++
 rtl/pipe_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the tinyriscv pipeline stall/flush controller.
//   pcs_e       FSM state encodings (RUN / MEM_WAIT / DIV_WAIT)
//   pipe_ctl_t  bundle of stop/flush controls driven toward the pipeline registers
//   CTL_INITIAL all controls inactive (normal flow)
//   src_hit     "this ID source reads register rd" helper
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      PCS_RUN      = 2'd0,
      PCS_MEM_WAIT = 2'd1,
      PCS_DIV_WAIT = 2'd2
   } pcs_e;

   localparam int PCS_DIV_CYCLES_DEF = 32;
   localparam int PCS_CNT_W_DEF      = 6;

   typedef struct packed {
      logic pc_stop;
      logic if_id_stop;
      logic id_ex_stop;
      logic ex_mem_stop;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
      logic mem_wb_flush;
   } pipe_ctl_t;

   localparam pipe_ctl_t CTL_INITIAL = '0;

   function automatic logic src_hit(input logic used, input logic [4:0] rs,
                                    input logic [4:0] rd);
      return used & (rs == rd);
   endfunction

endpackage

// File: rtl/pipe_ctrl_div_timer.sv
// pipe_div_timer: fixed-latency divider timer for pipe_ctrl.
// Holds the cycle counter and the div_done flag.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_load       divide accepted this cycle; counter loads DIV_CYCLES-1
//   i_active     controller is in DIV_WAIT; counter decrements
//   i_adv        EX/MEM is not held this cycle (divide can leave EX)
//   o_done       divide finished and the instruction has not left EX yet
//   o_expire     last stall cycle of the divide (active and cnt==1)
module pipe_div_timer
   import pipe_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = PCS_DIV_CYCLES_DEF,
   parameter int CNT_W      = PCS_CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_active,
   input  logic i_adv,
   output logic o_done,
   output logic o_expire
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_done;

   assign o_expire = i_active & (r_cnt == CNT_W'(1));
   assign o_done   = r_done;

   // The counter keeps running while a memory stall overrides the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= CNT_W'(DIV_CYCLES - 1);
      end else if (i_active) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // done stays set until the divide leaves EX, so a still-high
   // ex_div_start cannot start a second divide.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_done <= 1'b0;
      end else if (o_expire) begin
         r_done <= 1'b1;
      end else if (i_adv) begin
         r_done <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller for the 5-stage tinyriscv core.
// Resolves, highest priority first: data-memory wait, divider stall,
// taken-branch redirect, load-use hazard.
// Optional feature macro: PIPE_CTRL_DIV_EN (multi-cycle divider support).
// Without it ex_div_start is ignored and DIV_WAIT is never entered.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs1/2, id_rs1/2_used       ID source registers and their use flags
//   ex_rd, ex_mem_read            EX destination and load flag
//   ex_branch_taken               EX redirects the PC
//   ex_div_start                  EX instruction is a divide
//   dmem_req, dmem_ready          MEM-stage data memory handshake
//   pc_stop..ex_mem_stop          hold the register
//   if_id_flush..mem_wb_flush     load bubble values at the next edge
//   busy                          any stop active
//   state                         FSM state (debug)
//
// state        | meaning
// PCS_RUN      | normal flow, hazards resolved combinationally
// PCS_MEM_WAIT | data memory access outstanding
// PCS_DIV_WAIT | divider counting down, front end held
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = PCS_DIV_CYCLES_DEF,
   parameter int CNT_W      = PCS_CNT_W_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_rs1_used,
   input  logic       id_rs2_used,
   input  logic [4:0] ex_rd,
   input  logic       ex_mem_read,
   input  logic       ex_branch_taken,
   input  logic       ex_div_start,
   input  logic       dmem_req,
   input  logic       dmem_ready,
   output logic       pc_stop,
   output logic       if_id_stop,
   output logic       id_ex_stop,
   output logic       ex_mem_stop,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic       ex_mem_flush,
   output logic       mem_wb_flush,
   output logic       busy,
   output logic [1:0] state
);

   pcs_e      r_state;
   pcs_e      w_state_next;
   logic      w_memstall;
   logic      w_lu;
   logic      w_div_stall;
   pipe_ctl_t w_ctl;

   assign w_memstall = dmem_req & ~dmem_ready;
   assign w_lu       = ex_mem_read & (ex_rd != 5'd0)
                     & (src_hit(id_rs1_used, id_rs1, ex_rd)
                      | src_hit(id_rs2_used, id_rs2, ex_rd));

`ifdef PIPE_CTRL_DIV_EN
   logic w_divgo;
   logic w_div_done;
   logic w_div_expire;
   logic w_div_load;

   assign w_divgo     = ex_div_start & ~w_div_done & (r_state == PCS_RUN);
   assign w_div_stall = (r_state == PCS_DIV_WAIT) | w_divgo;
   assign w_div_load  = w_divgo & ~w_memstall;

   // ex_mem_stop is raised only by a memory stall, so "EX advances" is
   // simply the absence of one.
   pipe_div_timer #(
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_div_timer (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_div_load),
      .i_active (r_state == PCS_DIV_WAIT),
      .i_adv    (~w_memstall),
      .o_done   (w_div_done),
      .o_expire (w_div_expire)
   );
`else
   logic w_unused_div;

   assign w_unused_div = ex_div_start ^ (CNT_W'(DIV_CYCLES) == '0);
   assign w_div_stall  = 1'b0;
`endif

   always_comb begin
      w_ctl = CTL_INITIAL;
      if (w_memstall) begin
         w_ctl.pc_stop     = 1'b1;
         w_ctl.if_id_stop  = 1'b1;
         w_ctl.id_ex_stop  = 1'b1;
         w_ctl.ex_mem_stop = 1'b1;
      end else if (w_div_stall) begin
         // MEM/WB keep draining; a bubble enters EX/MEM behind the divide.
         w_ctl.pc_stop      = 1'b1;
         w_ctl.if_id_stop   = 1'b1;
         w_ctl.id_ex_stop   = 1'b1;
         w_ctl.ex_mem_flush = 1'b1;
      end else if (ex_branch_taken) begin
         w_ctl.if_id_flush = 1'b1;
         w_ctl.id_ex_flush = 1'b1;
      end else if (w_lu) begin
         w_ctl.pc_stop     = 1'b1;
         w_ctl.if_id_stop  = 1'b1;
         w_ctl.id_ex_flush = 1'b1;
      end
      // Reserved for exception flush.
      w_ctl.mem_wb_flush = 1'b0;
      if (rst) begin
         w_ctl = CTL_INITIAL;
      end
   end

   assign pc_stop      = w_ctl.pc_stop;
   assign if_id_stop   = w_ctl.if_id_stop;
   assign id_ex_stop   = w_ctl.id_ex_stop;
   assign ex_mem_stop  = w_ctl.ex_mem_stop;
   assign if_id_flush  = w_ctl.if_id_flush;
   assign id_ex_flush  = w_ctl.id_ex_flush;
   assign ex_mem_flush = w_ctl.ex_mem_flush;
   assign mem_wb_flush = w_ctl.mem_wb_flush;
   assign busy         = w_ctl.pc_stop | w_ctl.if_id_stop
                       | w_ctl.id_ex_stop | w_ctl.ex_mem_stop;
   assign state        = rst ? 2'd0 : r_state;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         PCS_RUN: begin
            if (w_memstall) begin
               w_state_next = PCS_MEM_WAIT;
`ifdef PIPE_CTRL_DIV_EN
            end else if (w_divgo) begin
               w_state_next = PCS_DIV_WAIT;
`endif
            end
         end
         PCS_MEM_WAIT: begin
            if (dmem_ready) begin
               w_state_next = PCS_RUN;
            end
         end
`ifdef PIPE_CTRL_DIV_EN
         // A memory stall here only overrides outputs; counting continues.
         PCS_DIV_WAIT: begin
            if (w_div_expire) begin
               w_state_next = PCS_RUN;
            end
         end
`endif
         default: w_state_next = PCS_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= PCS_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl (DIV_CYCLES=4, CNT_W=3).
// Divider scenarios are compiled when PIPE_CTRL_DIV_EN is defined; otherwise
// the bench checks that ex_div_start is ignored.
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken;
   logic       ex_div_start, dmem_req, dmem_ready;
   logic       pc_stop, if_id_stop, id_ex_stop, ex_mem_stop;
   logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, busy;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   logic [10:0] obs;

   // {pc,if_id,id_ex,ex_mem stop | if_id,id_ex,ex_mem,mem_wb flush | busy | state}
   localparam logic [10:0] O_IDLE  = 11'b0000_0000_0_00;
   localparam logic [10:0] O_LU    = 11'b1100_0100_1_00;
   localparam logic [10:0] O_BR    = 11'b0000_1100_0_00;
   localparam logic [10:0] O_MEM0  = 11'b1111_0000_1_00;
   localparam logic [10:0] O_MEM1  = 11'b1111_0000_1_01;
   localparam logic [10:0] O_MEM2  = 11'b1111_0000_1_10;
   localparam logic [10:0] O_DIV0  = 11'b1110_0010_1_00;
   localparam logic [10:0] O_DIV2  = 11'b1110_0010_1_10;
   localparam logic [10:0] O_REL1  = 11'b0000_0000_0_01;
   localparam logic [10:0] O_BR1   = 11'b0000_1100_0_01;

   pipe_ctrl #(.DIV_CYCLES(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .ex_div_start(ex_div_start),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_stop(pc_stop), .if_id_stop(if_id_stop), .id_ex_stop(id_ex_stop),
      .ex_mem_stop(ex_mem_stop), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
      .mem_wb_flush(mem_wb_flush), .busy(busy), .state(state)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] outs();
      return {pc_stop, if_id_stop, id_ex_stop, ex_mem_stop,
              if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, busy, state};
   endfunction

   task automatic clear_inputs();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; ex_div_start = 1'b0;
      dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
      ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs1_used = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL reset_hold: got %b expected %b", obs, O_IDLE); end
      advance();
      clear_inputs();
      rst = 1'b0;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL reset_release: got %b expected %b", obs, O_IDLE); end
   endtask

   task automatic test_load_use();
      advance();
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_LU) begin errors++; $display("FAIL lu_rs1: got %b expected %b", obs, O_LU); end
      advance();
      // Bubble is now in EX: the load moved on, hazard gone.
      ex_mem_read = 1'b0;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL lu_one_bubble: got %b expected %b", obs, O_IDLE); end
      advance();
      clear_inputs();
      ex_mem_read = 1'b1; ex_rd = 5'd17; id_rs1 = 5'd4; id_rs1_used = 1'b1;
      id_rs2 = 5'd17; id_rs2_used = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_LU) begin errors++; $display("FAIL lu_rs2: got %b expected %b", obs, O_LU); end
      advance();
      clear_inputs();
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL lu_x0: got %b expected %b", obs, O_IDLE); end
      advance();
      clear_inputs();
      ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs2 = 5'd9;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL lu_unused_src: got %b expected %b", obs, O_IDLE); end
      advance();
      clear_inputs();
      ex_rd = 5'd9; id_rs1 = 5'd9; id_rs1_used = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL lu_not_load: got %b expected %b", obs, O_IDLE); end
      advance();
      clear_inputs();
   endtask

   task automatic test_branch();
      ex_branch_taken = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_BR) begin errors++; $display("FAIL branch: got %b expected %b", obs, O_BR); end
      advance();
      ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_BR) begin errors++; $display("FAIL branch_over_lu: got %b expected %b", obs, O_BR); end
      advance();
      clear_inputs();
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL branch_after: got %b expected %b", obs, O_IDLE); end
      advance();
   endtask

   task automatic test_mem_wait();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); obs = outs(); checks++;
         if (obs !== ((i == 0) ? O_MEM0 : O_MEM1)) begin
            errors++; $display("FAIL mem_wait_%0d: got %b expected %b", i, obs, (i == 0) ? O_MEM0 : O_MEM1);
         end
         advance();
      end
      dmem_ready = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs[10:2] !== O_IDLE[10:2]) begin errors++; $display("FAIL mem_release: got %b expected %b", obs[10:2], O_IDLE[10:2]); end
      advance();
      clear_inputs();
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL mem_back_run: got %b expected %b", obs, O_IDLE); end
      advance();
   endtask

   task automatic test_mem_branch();
      dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_MEM0) begin errors++; $display("FAIL mem_over_branch: got %b expected %b", obs, O_MEM0); end
      advance();
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_MEM1) begin errors++; $display("FAIL mem_over_branch_2: got %b expected %b", obs, O_MEM1); end
      advance();
      dmem_ready = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_BR1) begin errors++; $display("FAIL branch_after_release: got %b expected %b", obs, O_BR1); end
      advance();
      clear_inputs();
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL mem_branch_done: got %b expected %b", obs, O_IDLE); end
      advance();
   endtask

   task automatic test_reset_mem();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      advance();
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_MEM1) begin errors++; $display("FAIL rst_mem_enter: got %b expected %b", obs, O_MEM1); end
      advance();
      dmem_req = 1'b0;
      rst = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL rst_mem_hold: got %b expected %b", obs, O_IDLE); end
      advance();
      rst = 1'b0;
      // Without the reset the FSM would still sit in MEM_WAIT (no ready seen).
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL rst_mem_run: got %b expected %b", obs, O_IDLE); end
      advance();
   endtask

`ifdef PIPE_CTRL_DIV_EN
   task automatic test_div();
      ex_div_start = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_DIV0) begin errors++; $display("FAIL div_t0: got %b expected %b", obs, O_DIV0); end
      advance();
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk); obs = outs(); checks++;
         if (obs !== O_DIV2) begin errors++; $display("FAIL div_t%0d: got %b expected %b", i, obs, O_DIV2); end
         advance();
      end
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL div_release: got %b expected %b", obs, O_IDLE); end
      advance();
      ex_div_start = 1'b0;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL div_after: got %b expected %b", obs, O_IDLE); end
      advance();
      // done flag cleared: a new divide starts right away.
      ex_div_start = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_DIV0) begin errors++; $display("FAIL div_second: got %b expected %b", obs, O_DIV0); end
      for (int i = 0; i < 4; i++) advance();
      ex_div_start = 1'b0;
      advance();
   endtask

   task automatic test_div_mem();
      ex_div_start = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_DIV0) begin errors++; $display("FAIL divmem_t0: got %b expected %b", obs, O_DIV0); end
      advance();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk); obs = outs(); checks++;
         if (obs !== O_MEM2) begin errors++; $display("FAIL divmem_t%0d: got %b expected %b", i, obs, O_MEM2); end
         advance();
      end
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_MEM0) begin errors++; $display("FAIL divmem_t4: got %b expected %b", obs, O_MEM0); end
      advance();
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_MEM1) begin errors++; $display("FAIL divmem_t5: got %b expected %b", obs, O_MEM1); end
      advance();
      dmem_ready = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_REL1) begin errors++; $display("FAIL divmem_t6: got %b expected %b", obs, O_REL1); end
      advance();
      clear_inputs();
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL divmem_t7: got %b expected %b", obs, O_IDLE); end
      advance();
   endtask

   task automatic test_div_reset();
      ex_div_start = 1'b1;
      advance();
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_DIV2) begin errors++; $display("FAIL divrst_t1: got %b expected %b", obs, O_DIV2); end
      advance();
      rst = 1'b1;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL divrst_hold: got %b expected %b", obs, O_IDLE); end
      advance();
      rst = 1'b0;
      ex_div_start = 1'b0;
      @(negedge clk); obs = outs(); checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL divrst_run: got %b expected %b", obs, O_IDLE); end
      advance();
   endtask
`else
   task automatic test_div_disabled();
      ex_div_start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); obs = outs(); checks++;
         if (obs !== O_IDLE) begin errors++; $display("FAIL div_ignored_%0d: got %b expected %b", i, obs, O_IDLE); end
         advance();
      end
      clear_inputs();
   endtask
`endif

   initial begin
      rst = 1'b1;
      clear_inputs();
      advance();
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_mem_branch();
      test_reset_mem();
`ifdef PIPE_CTRL_DIV_EN
      test_div();
      test_div_mem();
      test_div_reset();
`else
      test_div_disabled();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
